// File: rtl/zc_energy_pkg.sv
// Shared types, width helpers and default thresholds for the zero-crossing /
// energy frame feature extractor.
//   sign_state_t   : hysteresis sign tracker states
//   zc_width()     : width of a per-frame crossing count for a given frame length
//   energy_width() : width of a per-frame abs-sum for a given frame length
package zc_energy_pkg;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        POS     = 2'd1,
        NEG     = 2'd2
    } sign_state_t;

    localparam int DEF_FRAME_LEN = 256;
    localparam int DEF_HYST      = 16;
    localparam int DEF_ZC_MIN    = 16;
    localparam int DEF_ZC_MAX    = 64;
    localparam int DEF_ENERGY_TH = 200000;

    // A frame of N samples has at most N crossings, so log2(N)+1 bits hold it.
    function automatic int zc_width(input int frame_len);
        return $clog2(frame_len) + 1;
    endfunction

    // Each |sample| needs 17 bits (|-32768| = 32768); N of them add log2(N) bits.
    function automatic int energy_width(input int frame_len);
        return 17 + $clog2(frame_len);
    endfunction

endpackage

// File: rtl/zc_sign_tracker.sv
// Hysteresis sign tracker. Follows the sign of accepted samples that leave the
// dead band [-hyst, +hyst] and flags a crossing when the sign flips between
// POS and NEG. The first qualified sign after reset is not a crossing.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-low reset, returns the tracker to UNKNOWN
//   din      : signed 16-bit sample
//   in_en    : sample-valid strobe
//   hyst     : dead-band half width (0..16383)
//   crossing : combinational pulse, high in the cycle whose accepted sample
//              completes a crossing, so the caller can count it on that edge
module zc_sign_tracker
    import zc_energy_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] din,
    input  logic               in_en,
    input  logic        [15:0] hyst,
    output logic               crossing
);

    sign_state_t        state_r;
    sign_state_t        next_s;
    logic signed [16:0] din_ext_s;
    logic signed [16:0] hyst_pos_s;
    logic signed [16:0] hyst_neg_s;
    logic               above_s;
    logic               below_s;
    logic               crossing_s;

    // Dead-band comparisons at 17 bits so that -hyst never overflows.
    always_comb begin
        din_ext_s  = {din[15], din};
        hyst_pos_s = $signed({1'b0, hyst});
        hyst_neg_s = -hyst_pos_s;
        above_s    = (din_ext_s > hyst_pos_s);
        below_s    = (din_ext_s < hyst_neg_s);
    end

    // Next-state and crossing decode; state holds unless a sample is accepted.
    always_comb begin
        next_s     = state_r;
        crossing_s = 1'b0;
        if (in_en) begin
            case (state_r)
                UNKNOWN: begin
                    if (above_s) begin
                        next_s = POS;
                    end else if (below_s) begin
                        next_s = NEG;
                    end else begin
                        next_s = UNKNOWN;
                    end
                end
                POS: begin
                    if (below_s) begin
                        next_s     = NEG;
                        crossing_s = 1'b1;
                    end else begin
                        next_s = POS;
                    end
                end
                NEG: begin
                    if (above_s) begin
                        next_s     = POS;
                        crossing_s = 1'b1;
                    end else begin
                        next_s = NEG;
                    end
                end
                default: begin
                    next_s = UNKNOWN;
                end
            endcase
        end else begin
            next_s = state_r;
        end
    end

    // Sign state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= UNKNOWN;
        end else begin
            state_r <= next_s;
        end
    end

    assign crossing = crossing_s;

endmodule

// File: rtl/zc_energy_detector.sv
// Frame-based zero-crossing and energy feature extractor. Over frames of
// FRAME_LEN accepted samples it counts hysteresis-qualified crossings and sums
// |din|, then registers both totals plus a detect flag at the frame boundary.
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-low reset (discards any partial frame)
//   din         : signed 16-bit sample from the FIR stage
//   in_en       : sample-valid strobe
//   zc_count    : crossings in the last completed frame
//   energy      : sum of |din| over the last completed frame
//   detect      : ZC_MIN <= zc_count <= ZC_MAX and energy >= ENERGY_TH
//   frame_valid : one-cycle pulse when the three results update
module zc_energy_detector
    import zc_energy_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int HYST      = DEF_HYST,
    parameter int ZC_MIN    = DEF_ZC_MIN,
    parameter int ZC_MAX    = DEF_ZC_MAX,
    parameter int ENERGY_TH = DEF_ENERGY_TH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [15:0]                din,
    input  logic                              in_en,
    output logic [zc_width(FRAME_LEN)-1:0]     zc_count,
    output logic [energy_width(FRAME_LEN)-1:0] energy,
    output logic                              detect,
    output logic                              frame_valid
);

    localparam int ZC_W  = zc_width(FRAME_LEN);
    localparam int E_W   = energy_width(FRAME_LEN);
    localparam int CNT_W = $clog2(FRAME_LEN);

    localparam logic [15:0]      HYST_V  = 16'(HYST);
    localparam logic [CNT_W-1:0] LAST_V  = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [ZC_W-1:0]  zc_acc_r;
    logic [E_W-1:0]   e_acc_r;

    logic             crossing_s;
    logic [16:0]      abs_s;
    logic [ZC_W-1:0]  zc_sum_s;
    logic [E_W-1:0]   e_sum_s;
    logic             last_s;
    logic             zc_in_range_s;
    logic             e_above_s;
    logic             detect_s;

    zc_sign_tracker u_sign (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .in_en    (in_en),
        .hyst     (HYST_V),
        .crossing (crossing_s)
    );

    // Running totals including the current sample, so the closing sample's
    // contribution lands in the frame it closes.
    always_comb begin
        if (din[15]) begin
            abs_s = 17'd0 - {din[15], din};
        end else begin
            abs_s = {1'b0, din};
        end
        zc_sum_s      = zc_acc_r + ZC_W'(crossing_s);
        e_sum_s       = e_acc_r + E_W'(abs_s);
        last_s        = (cnt_r == LAST_V);
        zc_in_range_s = (32'(zc_sum_s) >= 32'(ZC_MIN)) && (32'(zc_sum_s) <= 32'(ZC_MAX));
        e_above_s     = (32'(e_sum_s) >= 32'(ENERGY_TH));
        detect_s      = zc_in_range_s && e_above_s;
    end

    // Frame counter, accumulators and registered frame results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r       <= {CNT_W{1'b0}};
            zc_acc_r    <= {ZC_W{1'b0}};
            e_acc_r     <= {E_W{1'b0}};
            zc_count    <= {ZC_W{1'b0}};
            energy      <= {E_W{1'b0}};
            detect      <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (in_en) begin
                if (last_s) begin
                    cnt_r       <= {CNT_W{1'b0}};
                    zc_acc_r    <= {ZC_W{1'b0}};
                    e_acc_r     <= {E_W{1'b0}};
                    zc_count    <= zc_sum_s;
                    energy      <= e_sum_s;
                    detect      <= detect_s;
                    frame_valid <= 1'b1;
                end else begin
                    cnt_r    <= cnt_r + CNT_W'(1);
                    zc_acc_r <= zc_sum_s;
                    e_acc_r  <= e_sum_s;
                end
            end
        end
    end

endmodule
